floating_point_multiplier_stream: RTL and testbench
===================================================

Name: floating_point_multiplier_stream

Overview:
Parametrised, fully pipelined IEEE-754-style floating-point multiplier with valid/ready backpressure, four selectable rounding modes and exception flags. It is the successor to the fixed-latency valid-only multiplier and sits in the same floating-point datapath. Downstream stalls propagate upstream without loss. It is width-generic through EXP_WIDTH/FRAC_WIDTH, and the FpDriver32/FpMonitor32 bench infrastructure applies at the 32-bit configuration.

Parameters:
EXP_WIDTH, 8, exponent field width; bias = 2^(EXP_WIDTH-1)-1
FRAC_WIDTH, 23, stored fraction width (hidden bit excluded)
STAGES, 3, pipeline depth in cycles, legal range 2..6; elaboration error outside this range

Ports:
clk_i  in  1  clock, all logic rising-edge
rst_ni  in  1  reset, synchronous, active-low
fp_a_i  in  1+EXP_WIDTH+FRAC_WIDTH  operand A {sign, exp, frac}
fp_b_i  in  1+EXP_WIDTH+FRAC_WIDTH  operand B
rnd_mode_i  in  2  rounding mode: 00 RNE, 01 RTZ, 10 RUP (toward +inf), 11 RDN (toward -inf); sampled with operands
valid_i  in  1  operand beat valid
ready_o  out  1  block accepts a beat this cycle
fp_o  out  1+EXP_WIDTH+FRAC_WIDTH  product
flags_o  out  4  {invalid, overflow, underflow, inexact}, aligned with fp_o
valid_o  out  1  result valid
ready_i  in  1  downstream accepts the result

Behaviour:
- Reset (rst_ni=0 at a clk_i edge): all stage valid bits, valid_o, fp_o and flags_o clear to 0. ready_o is forced to 0 while rst_ni=0. In-flight beats are discarded, including when reset is asserted mid-stream.
- Pipeline enable: en = ~valid_o | ready_i. ready_o = en & rst_ni. A beat is accepted when valid_i & ready_o.
- When en=1, every stage advances, including bubbles. When en=0, all stages hold. fp_o, flags_o and valid_o remain stable until the output handshake (valid_o & ready_i) completes.
- Latency: exactly STAGES cycles from acceptance to valid_o with no stall. Throughput is 1 beat/cycle when ready_i=1. Order is preserved and there is no reordering or drop.
- A beat accepted in the same cycle as an output handshake is legal and required for full throughput.
- Denormal handling: exp=0 inputs are treated as signed zero (flush-to-zero, no flag). Results below the minimum normal flush to signed zero with underflow=1 and inexact=1.
- Sign: result sign = sA ^ sB for all non-NaN results.
- Special cases, taking priority over arithmetic:
  - Any NaN input, or inf*0: canonical quiet NaN (sign 0, exp all ones, frac MSB 1, rest 0). invalid=1 only for inf*0 or a signalling NaN input (frac MSB 0).
  - inf*finite-nonzero or inf*inf: signed inf, no flags.
  - 0*finite: signed zero, no flags.
- Arithmetic:
  - Significand product is (FRAC_WIDTH+1)x(FRAC_WIDTH+1) giving 2*FRAC_WIDTH+2 bits.
  - Unbiased exponent sum is computed in EXP_WIDTH+2 signed bits: eA+eB-bias, +1 if product MSB set (normalise by 1-bit shift).
  - Guard bit plus sticky (OR of all discarded bits) drive rounding.
  - RNE: ties to even.
  - RUP/RDN: round the magnitude up only if inexact and the sign is positive/negative respectively.
  - A rounding carry-out renormalises and increments the exponent.
- Overflow (biased exp >= all-ones after rounding): overflow=1, inexact=1. Result is inf for RNE, for RUP with a positive sign and for RDN with a negative sign; otherwise max finite (exp all-ones-1, frac all ones).
- inexact=1 whenever guard|sticky is nonzero for a finite result.
- Stage partitioning is free, but STAGES must be met exactly.

Test Plan:
- 32-bit config, RNE: 0x3FC00000 * 0x40000000 -> 0x40400000, flags 0000, valid_o exactly STAGES cycles after acceptance.
- 0x3F800001 * 0x3F800001: RNE -> 0x3F800002, RTZ -> 0x3F800002, RUP -> 0x3F800003, RDN -> 0x3F800002; inexact=1 in every mode.
- 0x7F7FFFFF * 0x40000000: RNE -> 0x7F800000, RTZ -> 0x7F7FFFFF, flags overflow+inexact. 0x7F800000 * 0x00000000 -> 0x7FC00000 with invalid=1. 0xBF800000 * 0x00000000 -> 0x80000000.
- 0x00800000 * 0x3F000000 -> 0x00000000, underflow+inexact. 0x00400000 (denormal) * 0x40000000 -> 0x00000000, flags 0000.
- Backpressure: drive 10 back-to-back beats, hold ready_i=0 for 5 cycles mid-stream -> ready_o=0 during the stall, fp_o stable, all 10 results emerge in order, none lost or duplicated.
- Reset: pull rst_ni low for 1 cycle with 3 beats in flight -> valid_o=0 the next cycle, no stale result ever appears, and a fresh beat afterwards completes in STAGES cycles. Repeat with STAGES=2 and STAGES=6.

Source files
------------

// File: rtl/floating_point_multiplier_stream.sv
// Streaming IEEE-754-style multiplier with valid/ready flow control.
// Stage 1 decodes special operands and forms the significand product. Stage 2 normalises and rounds. Any further stages only add delay.
module floating_point_multiplier_stream #(
    parameter int EXP_WIDTH  = 8,
    parameter int FRAC_WIDTH = 23,
    parameter int STAGES     = 3
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [EXP_WIDTH+FRAC_WIDTH:0] fp_a_i,
    input  logic [EXP_WIDTH+FRAC_WIDTH:0] fp_b_i,
    input  logic [1:0]                    rnd_mode_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    output logic [EXP_WIDTH+FRAC_WIDTH:0] fp_o,
    output logic [3:0]                    flags_o,
    output logic                          valid_o,
    input  logic                          ready_i
);
    localparam int W  = 1 + EXP_WIDTH + FRAC_WIDTH;
    localparam int PW = 2 * FRAC_WIDTH + 2;
    localparam int XW = EXP_WIDTH + 2;
    localparam int NT = STAGES - 1;
    localparam logic [EXP_WIDTH-1:0] EXP_ONES = '1;
    localparam logic [EXP_WIDTH-1:0] EXP_MAXF = EXP_ONES - 1'b1;
    localparam logic [XW-1:0]        BIAS     = XW'((2 ** (EXP_WIDTH - 1)) - 1);
    localparam logic [W-1:0]         QNAN     = {1'b0, EXP_ONES, 1'b1, {(FRAC_WIDTH-1){1'b0}}};
    localparam logic [1:0] RM_RNE = 2'd0, RM_RTZ = 2'd1, RM_RUP = 2'd2, RM_RDN = 2'd3;

    if (STAGES < 2 || STAGES > 6) begin : g_bad_stages
        $error("floating_point_multiplier_stream: STAGES must be in 2..6");
    end

    // Handshake: a beat moves on valid & ready at a rising edge. The whole pipe advances
    // when the output slot is empty or being drained, so ready_o never looks at valid_i.
    logic en;
    assign en      = ~valid_o | ready_i;
    assign ready_o = en & rst_ni;

    logic                  sa, sb;
    logic [EXP_WIDTH-1:0]  ea, eb;
    logic [FRAC_WIDTH-1:0] fa, fb;
    assign {sa, ea, fa} = fp_a_i;
    assign {sb, eb, fb} = fp_b_i;

    logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan, inf_zero;
    assign a_zero   = (ea == '0);
    assign b_zero   = (eb == '0);
    assign a_inf    = (ea == EXP_ONES) && (fa == '0);
    assign b_inf    = (eb == EXP_ONES) && (fb == '0);
    assign a_nan    = (ea == EXP_ONES) && (fa != '0);
    assign b_nan    = (eb == EXP_ONES) && (fb != '0);
    assign a_snan   = a_nan & ~fa[FRAC_WIDTH-1];
    assign b_snan   = b_nan & ~fb[FRAC_WIDTH-1];
    assign inf_zero = (a_inf & b_zero) | (a_zero & b_inf);

    logic           sign_d, spec_d;
    logic [W-1:0]   spec_fp_d;
    logic [3:0]     spec_flags_d;
    logic [XW-1:0]  exp_d;
    logic [PW-1:0]  prod_d;
    assign sign_d = sa ^ sb;
    assign exp_d  = {2'b00, ea} + {2'b00, eb} - BIAS;
    assign prod_d = PW'({1'b1, fa}) * PW'({1'b1, fb});

    always_comb begin
        spec_d       = 1'b1;
        spec_flags_d = 4'b0000;
        spec_fp_d    = {sign_d, {(W-1){1'b0}}};
        if (a_nan | b_nan | inf_zero) begin
            spec_fp_d    = QNAN;
            spec_flags_d = {inf_zero | a_snan | b_snan, 3'b000};
        end else if (a_inf | b_inf) begin
            spec_fp_d = {sign_d, EXP_ONES, {FRAC_WIDTH{1'b0}}};
        end else if (!(a_zero | b_zero)) begin
            spec_d = 1'b0;
        end
    end

    logic          s1_vld_q, s1_spec_q, s1_sign_q;
    logic [W-1:0]  s1_spec_fp_q;
    logic [3:0]    s1_spec_flags_q;
    logic [1:0]    s1_rnd_q;
    logic [XW-1:0] s1_exp_q;
    logic [PW-1:0] s1_prod_q;

    logic                  msb, guard, sticky, inexact, inc, carry, ovf, unf, to_inf;
    logic [PW-1:0]         norm;
    logic [FRAC_WIDTH:0]   mant;
    logic [FRAC_WIDTH+1:0] mant_r;
    logic [FRAC_WIDTH-1:0] frac_r;
    logic [XW-1:0]         exp_r;
    logic [W-1:0]          res_fp;
    logic [3:0]            res_flags;

    always_comb begin
        msb     = s1_prod_q[PW-1];
        norm    = msb ? s1_prod_q : (s1_prod_q << 1);
        mant    = norm[PW-1:FRAC_WIDTH+1];
        guard   = norm[FRAC_WIDTH];
        sticky  = |norm[FRAC_WIDTH-1:0];
        inexact = guard | sticky;
        case (s1_rnd_q)
            RM_RNE:  inc = guard & (sticky | mant[0]);
            RM_RTZ:  inc = 1'b0;
            RM_RUP:  inc = inexact & ~s1_sign_q;
            RM_RDN:  inc = inexact & s1_sign_q;
            default: inc = 1'b0;
        endcase
        mant_r = {1'b0, mant} + {{(FRAC_WIDTH+1){1'b0}}, inc};
        carry  = mant_r[FRAC_WIDTH+1];
        frac_r = carry ? mant_r[FRAC_WIDTH:1] : mant_r[FRAC_WIDTH-1:0];
        // exp_r is two's complement; a set top bit means the product fell below 2^(1-bias)
        exp_r  = s1_exp_q + {{(XW-1){1'b0}}, msb} + {{(XW-1){1'b0}}, carry};
        unf    = exp_r[XW-1] | (exp_r == '0);
        ovf    = ~exp_r[XW-1] & (exp_r[XW-2:0] >= {1'b0, EXP_ONES});
        to_inf = (s1_rnd_q == RM_RNE) | ((s1_rnd_q == RM_RUP) & ~s1_sign_q)
               | ((s1_rnd_q == RM_RDN) & s1_sign_q);
        res_fp    = {s1_sign_q, exp_r[EXP_WIDTH-1:0], frac_r};
        res_flags = {3'b000, inexact};
        if (s1_spec_q) begin
            res_fp    = s1_spec_fp_q;
            res_flags = s1_spec_flags_q;
        end else if (ovf) begin
            res_flags = 4'b0101;
            res_fp    = to_inf ? {s1_sign_q, EXP_ONES, {FRAC_WIDTH{1'b0}}}
                               : {s1_sign_q, EXP_MAXF, {FRAC_WIDTH{1'b1}}};
        end else if (unf) begin
            res_flags = 4'b0011;
            res_fp    = {s1_sign_q, {(W-1){1'b0}}};
        end
    end

    logic [NT-1:0] vld_q;
    logic [W-1:0]  fp_q  [NT];
    logic [3:0]    flg_q [NT];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s1_vld_q        <= 1'b0;
            s1_spec_q       <= 1'b0;
            s1_sign_q       <= 1'b0;
            s1_spec_fp_q    <= '0;
            s1_spec_flags_q <= '0;
            s1_rnd_q        <= '0;
            s1_exp_q        <= '0;
            s1_prod_q       <= '0;
            vld_q           <= '0;
            for (int i = 0; i < NT; i++) begin
                fp_q[i]  <= '0;
                flg_q[i] <= '0;
            end
        end else if (en) begin
            s1_vld_q        <= valid_i & ready_o;
            s1_spec_q       <= spec_d;
            s1_sign_q       <= sign_d;
            s1_spec_fp_q    <= spec_fp_d;
            s1_spec_flags_q <= spec_flags_d;
            s1_rnd_q        <= rnd_mode_i;
            s1_exp_q        <= exp_d;
            s1_prod_q       <= prod_d;
            vld_q[0]        <= s1_vld_q;
            fp_q[0]         <= res_fp;
            flg_q[0]        <= res_flags;
            for (int i = 1; i < NT; i++) begin
                vld_q[i] <= vld_q[i-1];
                fp_q[i]  <= fp_q[i-1];
                flg_q[i] <= flg_q[i-1];
            end
        end
    end

    assign valid_o = vld_q[NT-1];
    assign fp_o    = fp_q[NT-1];
    assign flags_o = flg_q[NT-1];
endmodule

// File: tb/tb_floating_point_multiplier_stream.sv
// Bench for floating_point_multiplier_stream at 32 bits, with three instances of depth 3, 2 and 6.
// Results are checked against an exact-integer rounding model kept in this file.
module tb_floating_point_multiplier_stream;
    localparam int NI = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] a_i   [NI];
    logic [31:0] b_i   [NI];
    logic [1:0]  rm_i  [NI];
    logic        v_i   [NI];
    logic        rdy_i [NI];
    logic [31:0] fpo   [NI];
    logic [3:0]  flo   [NI];
    logic        vo    [NI];
    logic        rdyo  [NI];

    always #5 clk = ~clk;

    for (genvar k = 0; k < NI; k++) begin : g_dut
        floating_point_multiplier_stream #(
            .EXP_WIDTH (8),
            .FRAC_WIDTH(23),
            .STAGES    (k == 0 ? 3 : (k == 1 ? 2 : 6))
        ) u_dut (
            .clk_i     (clk),
            .rst_ni    (rst_n),
            .fp_a_i    (a_i[k]),
            .fp_b_i    (b_i[k]),
            .rnd_mode_i(rm_i[k]),
            .valid_i   (v_i[k]),
            .ready_o   (rdyo[k]),
            .fp_o      (fpo[k]),
            .flags_o   (flo[k]),
            .valid_o   (vo[k]),
            .ready_i   (rdy_i[k])
        );
    end

    int          n_cmp = 0;
    int          n_fail = 0;
    int          out_cnt [NI];
    logic [35:0] exp_q [$];
    logic [31:0] st_a [$];
    logic [31:0] st_b [$];
    logic [1:0]  st_rm [$];

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: exact integer product, rounding decided from the discarded remainder vs one half.
    function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] rm);
        logic s;
        int ea, eb, e, sh;
        bit za, zb, ia, ib, na, nb, sna, snb, ivz, inx, up, to_inf;
        longint unsigned p, q, rem, half;
        s   = a[31] ^ b[31];
        ea  = int'(a[30:23]);
        eb  = int'(b[30:23]);
        za  = (ea == 0);
        zb  = (eb == 0);
        ia  = (ea == 255) && (a[22:0] == 0);
        ib  = (eb == 255) && (b[22:0] == 0);
        na  = (ea == 255) && (a[22:0] != 0);
        nb  = (eb == 255) && (b[22:0] != 0);
        sna = na && !a[22];
        snb = nb && !b[22];
        ivz = (ia && zb) || (za && ib);
        if (na || nb || ivz) return {ivz || sna || snb, 3'b000, 32'h7FC00000};
        if (ia || ib) return {4'b0000, s, 8'hFF, 23'h0};
        if (za || zb) return {4'b0000, s, 31'h0};
        p    = longint'({1'b1, a[22:0]}) * longint'({1'b1, b[22:0]});
        sh   = (p >= (64'd1 << 47)) ? 24 : 23;
        q    = p >> sh;
        rem  = p - (q << sh);
        half = 64'd1 << (sh - 1);
        e    = ea + eb - 127 + (sh - 23);
        inx  = (rem != 0);
        case (rm)
            2'd0:    up = (rem > half) || ((rem == half) && q[0]);
            2'd2:    up = inx && !s;
            2'd3:    up = inx && s;
            default: up = 1'b0;
        endcase
        if (up) q = q + 1;
        if (q == (64'd1 << 24)) begin
            q = q >> 1;
            e = e + 1;
        end
        if (e >= 255) begin
            to_inf = (rm == 2'd0) || ((rm == 2'd2) && !s) || ((rm == 2'd3) && s);
            return to_inf ? {4'b0101, s, 8'hFF, 23'h0} : {4'b0101, s, 8'hFE, 23'h7FFFFF};
        end
        if (e <= 0) return {4'b0011, s, 31'h0};
        return {3'b000, inx, s, e[7:0], q[22:0]};
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [31:0] r;
        logic [7:0]  e;
        logic [22:0] f;
        r = $urandom;
        f = r[22:0];
        case ($urandom_range(0, 11))
            0:       e = 8'h00;
            1:       e = 8'hFF;
            2, 3:    e = 8'($urandom_range(120, 135));
            4:       e = 8'($urandom_range(190, 254));
            5:       e = 8'($urandom_range(1, 64));
            default: e = 8'($urandom_range(1, 254));
        endcase
        case ($urandom_range(0, 9))
            0:       f = 23'h0;
            1:       f = 23'h7FFFFF;
            2:       f = 23'h1;
            default: ;
        endcase
        return {r[31], e, f};
    endfunction

    // One compare process: protocol rules, hold-during-stall, reset state and scoreboard.
    logic        stall_q [NI];
    logic [36:0] held_q  [NI];
    logic        rst_low_last = 1'b0;
    always @(negedge clk) begin : cmp
        logic [35:0] e;
        for (int k = 0; k < NI; k++) begin
            if (rst_low_last) chk("reset_outputs", {3'b0, vo[k], flo[k], fpo[k]}, 40'h0);
            if (!rst_n) begin
                chk("ready_in_reset", {39'h0, rdyo[k]}, 40'h0);
                stall_q[k] = 1'b0;
            end else begin
                chk("ready_rule", {39'h0, rdyo[k]}, {39'h0, (!vo[k] || rdy_i[k])});
                if (stall_q[k]) chk("held_output", {3'b0, vo[k], flo[k], fpo[k]}, {3'b0, held_q[k]});
                if (vo[k] && rdy_i[k]) begin
                    if (exp_q.size() == 0) begin
                        chk("stale_result", {39'h0, vo[k]}, 40'h0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("result", {4'h0, flo[k], fpo[k]}, {4'h0, e});
                        out_cnt[k]++;
                    end
                end
                if (v_i[k] && rdyo[k]) exp_q.push_back(model(a_i[k], b_i[k], rm_i[k]));
                stall_q[k] = vo[k] && !rdy_i[k];
                held_q[k]  = {vo[k], flo[k], fpo[k]};
            end
        end
        if (!rst_n) exp_q.delete();
        rst_low_last = !rst_n;
    end

    task automatic run_stream(input int k, input int n, input bit rnd_v, input bit rnd_r,
                              input int stall_at, input int stall_len, input bit directed);
        int          sent = 0;
        int          cyc = 0;
        bit          have = 0;
        logic [31:0] ca = '0, cb = '0;
        logic [1:0]  cr = '0;
        while ((sent < n || exp_q.size() != 0) && cyc < 8000) begin
            if (!have && sent < n) begin
                if (directed) begin
                    ca = st_a.pop_front();
                    cb = st_b.pop_front();
                    cr = st_rm.pop_front();
                end else begin
                    ca = rand_fp();
                    cb = rand_fp();
                    cr = 2'($urandom_range(0, 3));
                end
                have = 1;
            end
            a_i[k]   = ca;
            b_i[k]   = cb;
            rm_i[k]  = cr;
            v_i[k]   = have && (!rnd_v || $urandom_range(0, 3) != 0);
            rdy_i[k] = (cyc >= stall_at && cyc < stall_at + stall_len) ? 1'b0
                     : (rnd_r ? ($urandom_range(0, 2) != 0) : 1'b1);
            @(negedge clk);
            if (v_i[k] && rdyo[k]) begin
                sent++;
                have = 0;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        v_i[k]   = 1'b0;
        rdy_i[k] = 1'b1;
        if (cyc >= 8000) chk("stream_timeout", 40'(cyc), 40'(0));
    endtask

    task automatic latency_check(input int k, input int stg);
        int n;
        repeat (2) @(posedge clk);
        #1;
        a_i[k]   = 32'h3FC00000;
        b_i[k]   = 32'h40000000;
        rm_i[k]  = 2'd0;
        rdy_i[k] = 1'b1;
        v_i[k]   = 1'b1;
        @(posedge clk);
        #1;
        v_i[k] = 1'b0;
        n = 1;
        while (!vo[k] && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("latency", 40'(n), 40'(stg));
        chk("latency_value", {4'h0, flo[k], fpo[k]}, {8'h0, 32'h40400000});
        repeat (2) @(posedge clk);
        #1;
        chk("latency_drained", 40'(exp_q.size()), 40'(0));
    endtask

    task automatic reset_midstream(input int k, input int stg);
        rdy_i[k] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_i[k]  = rand_fp();
            b_i[k]  = rand_fp();
            rm_i[k] = 2'($urandom_range(0, 3));
            v_i[k]  = 1'b1;
            @(posedge clk);
            #1;
        end
        v_i[k] = 1'b0;
        rst_n  = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("reset_mid_valid", {39'h0, vo[k]}, 40'h0);
        repeat (stg + 3) @(posedge clk);
        #1;
        latency_check(k, stg);
    endtask

    logic [31:0] pin_a  [$];
    logic [31:0] pin_b  [$];
    logic [1:0]  pin_rm [$];
    logic [35:0] pin_e  [$];

    task automatic add_pin(input logic [31:0] a, input logic [31:0] b, input logic [1:0] rm,
                           input logic [3:0] fl, input logic [31:0] r);
        pin_a.push_back(a);
        pin_b.push_back(b);
        pin_rm.push_back(rm);
        pin_e.push_back({fl, r});
    endtask

    initial begin
        int base;
        rst_n = 1'b0;
        for (int k = 0; k < NI; k++) begin
            a_i[k] = '0; b_i[k] = '0; rm_i[k] = '0;
            v_i[k] = 1'b0; rdy_i[k] = 1'b1;
            out_cnt[k] = 0; stall_q[k] = 1'b0; held_q[k] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        add_pin(32'h3FC00000, 32'h40000000, 2'd0, 4'b0000, 32'h40400000);
        add_pin(32'h3F800001, 32'h3F800001, 2'd0, 4'b0001, 32'h3F800002);
        add_pin(32'h3F800001, 32'h3F800001, 2'd1, 4'b0001, 32'h3F800002);
        add_pin(32'h3F800001, 32'h3F800001, 2'd2, 4'b0001, 32'h3F800003);
        add_pin(32'h3F800001, 32'h3F800001, 2'd3, 4'b0001, 32'h3F800002);
        add_pin(32'h7F7FFFFF, 32'h40000000, 2'd0, 4'b0101, 32'h7F800000);
        add_pin(32'h7F7FFFFF, 32'h40000000, 2'd1, 4'b0101, 32'h7F7FFFFF);
        add_pin(32'hFF7FFFFF, 32'h40000000, 2'd2, 4'b0101, 32'hFF7FFFFF);
        add_pin(32'h7F800000, 32'h00000000, 2'd0, 4'b1000, 32'h7FC00000);
        add_pin(32'hBF800000, 32'h00000000, 2'd0, 4'b0000, 32'h80000000);
        add_pin(32'h00800000, 32'h3F000000, 2'd0, 4'b0011, 32'h00000000);
        add_pin(32'h00400000, 32'h40000000, 2'd0, 4'b0000, 32'h00000000);
        add_pin(32'h7F800001, 32'h3F800000, 2'd0, 4'b1000, 32'h7FC00000);
        add_pin(32'hFFC00000, 32'h3F800000, 2'd0, 4'b0000, 32'h7FC00000);
        add_pin(32'hFF800000, 32'h40000000, 2'd0, 4'b0000, 32'hFF800000);
        add_pin(32'hBF800000, 32'h3F800000, 2'd0, 4'b0000, 32'hBF800000);
        add_pin(32'h3F800001, 32'hBF800001, 2'd3, 4'b0001, 32'hBF800003);

        foreach (pin_a[i]) begin
            chk("model_pin", {4'h0, model(pin_a[i], pin_b[i], pin_rm[i])}, {4'h0, pin_e[i]});
            st_a.push_back(pin_a[i]);
            st_b.push_back(pin_b[i]);
            st_rm.push_back(pin_rm[i]);
        end
        run_stream(0, pin_a.size(), 1'b0, 1'b0, -1, 0, 1'b1);

        latency_check(0, 3);

        base = out_cnt[0];
        run_stream(0, 10, 1'b0, 1'b0, 5, 5, 1'b0);
        chk("backpressure_count", 40'(out_cnt[0] - base), 40'(10));

        run_stream(0, 1500, 1'b1, 1'b1, -1, 0, 1'b0);

        reset_midstream(0, 3);
        reset_midstream(1, 2);
        reset_midstream(2, 6);

        base = out_cnt[1];
        run_stream(1, 300, 1'b1, 1'b1, 20, 5, 1'b0);
        chk("stages2_count", 40'(out_cnt[1] - base), 40'(300));
        base = out_cnt[2];
        run_stream(2, 300, 1'b1, 1'b1, 20, 5, 1'b0);
        chk("stages6_count", 40'(out_cnt[2] - base), 40'(300));

        chk("final_queue_empty", 40'(exp_q.size()), 40'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
